// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose:
//   Shares one APB bus between NUM_REQ local requesters. A winner is picked
//   in IDLE, driven through APB SETUP and ACCESS, and the owner gets back a
//   one-cycle completion pulse. For reads, the data comes from a CAPTURE
//   cycle. The target slaves have no PREADY. They register PRDATA at the end
//   of ACCESS, and it stays valid for one cycle only, which is why CAPTURE
//   exists.
//
// Configuration macro:
//   APB_ARB_FIXED_PRIO_EN - when defined, the lowest index always wins and
//                           no round-robin pointer is built. When undefined
//                           (the default), arbitration is round-robin.
//                           Timing is the same in both modes.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   req_valid    per-requester request valid
//   req_ready    one-hot accept, high only for the IDLE winner
//   req_write    per-requester direction (1 = write)
//   req_addr     packed addresses, requester i at [i*addrWidth +: addrWidth]
//   req_wdata    packed write data, same packing
//   rsp_valid    one-cycle completion pulse to the owner
//   rsp_rdata    read data, valid with rsp_valid for reads, otherwise held
//   PADDR, PWRITE, PSEL, PENABLE, PWDATA, PRDATA   APB master signals
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*addrWidth-1:0]   req_addr,
  input  logic [NUM_REQ*dataWidth-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [dataWidth-1:0]           rsp_rdata,
  output logic [addrWidth-1:0]           PADDR,
  output logic                           PWRITE,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic [dataWidth-1:0]           PWDATA,
  input  logic [dataWidth-1:0]           PRDATA
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ACCESS  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   w_winner;
  logic            w_found;
  logic            w_accept;
  logic [addrWidth-1:0] w_sel_addr;
  logic [dataWidth-1:0] w_sel_wdata;

`ifndef APB_ARB_FIXED_PRIO_EN
  logic [PW-1:0]   r_ptr;
`endif

  // Winner search: scan all requesters, starting at the round-robin pointer
  // and wrapping around. In fixed-priority mode the scan starts at index 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
`ifdef APB_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_found;
  assign w_sel_addr  = req_addr[int'(w_winner)*addrWidth +: addrWidth];
  assign w_sel_wdata = req_wdata[int'(w_winner)*dataWidth +: dataWidth];

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_winner] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_SETUP;
      S_SETUP:   w_state_next = S_ACCESS;
      S_ACCESS:  w_state_next = PWRITE ? S_IDLE : S_CAPTURE;
      S_CAPTURE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // APB outputs and responses are registered. PSEL and PENABLE are set one
  // edge ahead of the state they belong to, so they line up with SETUP and
  // ACCESS. PADDR, PWRITE and PWDATA only load on accept, so they hold
  // through IDLE and CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      r_owner   <= '0;
    end else begin
      rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            PADDR   <= w_sel_addr;
            PWDATA  <= w_sel_wdata;
            PWRITE  <= req_write[w_winner];
            r_owner <= w_winner;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (PWRITE) rsp_valid[r_owner] <= 1'b1;
        end
        S_CAPTURE: begin
          // The slave presents PRDATA in this cycle only.
          rsp_rdata          <= PRDATA;
          rsp_valid[r_owner] <= 1'b1;
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

`ifndef APB_ARB_FIXED_PRIO_EN
  // The pointer moves past the requester that was just accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      if (w_winner == PW'(NUM_REQ - 1)) r_ptr <= '0;
      else                             r_ptr <= w_winner + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Purpose:
//   Drives directed request patterns into apb_master_arbiter and models the
//   APB slave as a small memory. Expected grants and responses are queued
//   when stimulus is issued. A monitor on the falling edge checks APB phase
//   timing, grant order and response content against those queues.
//   Honours APB_ARB_FIXED_PRIO_EN, which changes the expected grant orders.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   PADDR;
  logic            PWRITE;
  logic            PSEL;
  logic            PENABLE;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;

  apb_master_arbiter #(.NUM_REQ(N), .addrWidth(AW), .dataWidth(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB slave model: no PREADY; PRDATA is registered at the end of ACCESS
  // and valid for one cycle. Outside that cycle it shows a marker value.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PRDATA <= 32'hBAD0BAD0;
    end else if (PSEL && PENABLE) begin
      if (PWRITE) begin
        mem[PADDR[7:0]] <= PWDATA;
        PRDATA          <= 32'hBAD0BAD0;
      end else begin
        PRDATA <= mem[PADDR[7:0]];
      end
    end else begin
      PRDATA <= 32'hBAD0BAD0;
    end
  end

  // Scoreboard queues
  typedef struct {
    int          owner;
    bit          rd;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t        rsp_q[$];
  int          grant_q[$];
  logic [31:0] exp_last = 32'h0;

  function automatic void push_rsp(int o, bit rd, logic [31:0] d);
    rsp_t e;
    if (rd) exp_last = d;
    e.owner = o;
    e.rd    = rd;
    e.rdata = exp_last;
    rsp_q.push_back(e);
  endfunction

  // Monitor
  int          grant_cyc [N];
  bit          t_active = 1'b0;
  int          t_grant;
  bit          t_rd;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        t_active = 1'b0;
      end else begin
        if (t_active) begin
          int d;
          d = cyc - t_grant;
          if (d == 1) begin
            chk("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
            chk("setup_paddr", PADDR, t_addr);
            chk("setup_pwrite", PWRITE, !t_rd);
            if (!t_rd) chk("setup_pwdata", PWDATA, t_wdata);
          end else if (d == 2) begin
            chk("access_psel_penable", {PSEL, PENABLE}, 2'b11);
            chk("access_paddr", PADDR, t_addr);
          end else if (d == 3 && t_rd) begin
            chk("capture_psel_penable", {PSEL, PENABLE}, 2'b00);
          end
          if (d >= 3) t_active = 1'b0;
        end
        if (rsp_valid != '0) begin
          if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid %b expected none", rsp_valid);
          end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            $display("rsp owner %0d %s rdata %h cycle %0d", e.owner, e.rd ? "read" : "write", rsp_rdata, cyc);
            chk("rsp_valid", rsp_valid, 64'(1) << e.owner);
            chk("rsp_latency", cyc - grant_cyc[e.owner], e.rd ? 4 : 3);
            chk("rsp_rdata", rsp_rdata, e.rdata);
          end
        end
        if (req_ready != '0) begin
          if (grant_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got req_ready %b expected none", req_ready);
          end else begin
            int g;
            g = grant_q.pop_front();
            $display("grant req%0d cycle %0d", g, cyc);
            chk("grant_onehot", req_ready, 64'(1) << g);
            grant_cyc[g] = cyc;
            t_active = 1'b1;
            t_grant  = cyc;
            t_rd     = !req_write[g];
            t_addr   = req_addr[g*AW +: AW];
            t_wdata  = req_wdata[g*DW +: DW];
          end
        end
      end
    end
  end

  // Requester agent: raise a request, hold it until accepted, then drop it.
  task automatic do_req(int i, bit wr, logic [31:0] a, logic [31:0] d);
    int n;
    n = 0;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]          = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 200);
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: req%0d got no grant expected grant within 200 cycles", i);
      req_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_rsp_queue", rsp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int          pre_req  [6] = '{2, 3, 0, 1, 2, 3};
  logic [31:0] pre_addr [6] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
  logic [31:0] pre_data [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                32'h44444444, 32'h55555555, 32'h77777777};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1;
    chk("reset_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_rsp", {rsp_valid, req_ready}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single write then read-back by another requester.
    grant_q.push_back(0);
    push_rsp(0, 1'b0, 32'h0);
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    drain();
    grant_q.push_back(1);
    push_rsp(1, 1'b1, 32'hDEADBEEF);
    do_req(1, 1'b0, 32'h10, 32'h0);
    drain();

    // Preload memory. Pointer walks 2,3,0,1,2,3 and ends at 0.
    for (int k = 0; k < 6; k++) begin
      grant_q.push_back(pre_req[k]);
      push_rsp(pre_req[k], 1'b0, 32'h0);
      do_req(pre_req[k], 1'b1, pre_addr[k], pre_data[k]);
    end
    drain();

    // All four requesters hold reads; requester 0 re-requests after its grant.
`ifdef APB_ARB_FIXED_PRIO_EN
    grant_q.push_back(0); push_rsp(0, 1'b1, 32'h33333333);
    grant_q.push_back(0); push_rsp(0, 1'b1, 32'h55555555);
    grant_q.push_back(1); push_rsp(1, 1'b1, 32'h44444444);
    grant_q.push_back(2); push_rsp(2, 1'b1, 32'h11111111);
    grant_q.push_back(3); push_rsp(3, 1'b1, 32'h22222222);
`else
    grant_q.push_back(0); push_rsp(0, 1'b1, 32'h33333333);
    grant_q.push_back(1); push_rsp(1, 1'b1, 32'h44444444);
    grant_q.push_back(2); push_rsp(2, 1'b1, 32'h11111111);
    grant_q.push_back(3); push_rsp(3, 1'b1, 32'h22222222);
    grant_q.push_back(0); push_rsp(0, 1'b1, 32'h55555555);
`endif
    fork
      begin
        do_req(0, 1'b0, 32'h28, 32'h0);
        do_req(0, 1'b0, 32'h30, 32'h0);
      end
      do_req(1, 1'b0, 32'h2C, 32'h0);
      do_req(2, 1'b0, 32'h20, 32'h0);
      do_req(3, 1'b0, 32'h24, 32'h0);
    join
    drain();

    // Move the pointer to 3, then race requesters 2 and 3.
    grant_q.push_back(2);
    push_rsp(2, 1'b0, 32'h0);
    do_req(2, 1'b1, 32'h38, 32'h66666666);
    drain();
`ifdef APB_ARB_FIXED_PRIO_EN
    grant_q.push_back(2); push_rsp(2, 1'b1, 32'h66666666);
    grant_q.push_back(3); push_rsp(3, 1'b1, 32'h77777777);
`else
    grant_q.push_back(3); push_rsp(3, 1'b1, 32'h77777777);
    grant_q.push_back(2); push_rsp(2, 1'b1, 32'h66666666);
`endif
    fork
      do_req(2, 1'b0, 32'h38, 32'h0);
      do_req(3, 1'b0, 32'h34, 32'h0);
    join
    drain();

    // Reset during ACCESS of a read. Accepting req1 moves the pointer to 2.
    grant_q.push_back(1);
    do_req(1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_psel_penable", {PSEL, PENABLE}, 2'b00);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_rdata", rsp_rdata, 0);
    exp_last = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // With the pointer back at 0, req1 wins over req2.
    grant_q.push_back(1); push_rsp(1, 1'b0, 32'h0);
    grant_q.push_back(2); push_rsp(2, 1'b1, 32'h66666666);
    fork
      do_req(1, 1'b1, 32'h40, 32'hCAFEF00D);
      do_req(2, 1'b0, 32'h38, 32'h0);
    join
    drain();

`ifdef APB_ARB_FIXED_PRIO_EN
    // Requester 0 keeps requesting; requester 1 waits until it stops.
    grant_q.push_back(0); push_rsp(0, 1'b0, 32'h0);
    grant_q.push_back(0); push_rsp(0, 1'b0, 32'h0);
    grant_q.push_back(0); push_rsp(0, 1'b0, 32'h0);
    grant_q.push_back(1); push_rsp(1, 1'b0, 32'h0);
    fork
      begin
        do_req(0, 1'b1, 32'h50, 32'hA0A0A0A0);
        do_req(0, 1'b1, 32'h54, 32'hA1A1A1A1);
        do_req(0, 1'b1, 32'h58, 32'hA2A2A2A2);
      end
      do_req(1, 1'b1, 32'h60, 32'hB0B0B0B0);
    join
    drain();
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("grant_queue_empty", grant_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
